// File: rtl/le_config_loader_pkg.sv
// Shared constants and types for the logic-element configuration loader:
// word layout of one LE configuration, the frame sync header and FSM states.
package le_cfg_pkg;

  localparam int CFG_W = 32;

  localparam int LUT_LSB    = 0;
  localparam int LUT_W      = 16;
  localparam int INS_LSB    = 16;
  localparam int INS_W      = 8;
  localparam int N_CONF_LSB = 24;
  localparam int E_CONF_LSB = 26;
  localparam int W_CONF_LSB = 28;
  localparam int S_CONF_LSB = 30;
  localparam int CONF_W     = 2;

  localparam int             HDR_W    = 8;
  localparam logic [7:0]     SYNC_HDR = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    COMMIT  = 2'd3
  } le_cfg_state_e;

  // Extract the LUT truth table from one LE configuration word.
  function automatic logic [LUT_W-1:0] le_lut(input logic [CFG_W-1:0] word);
    return word[LUT_LSB +: LUT_W];
  endfunction

endpackage

// File: rtl/le_config_loader_if.sv
// Handshake and configuration bus between the genome source (master) and
// the configuration loader (slave). NUM_LE must match the loader instance.
interface le_cfg_if
  import le_cfg_pkg::*;
#(
  parameter int NUM_LE = 4
);
  logic                    start;
  logic                    abort;
  logic                    cfg_bit;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [NUM_LE*CFG_W-1:0] cfg_active;
  logic                    busy;
  logic                    done;
  logic                    hdr_err;
  logic [7:0]              commit_cnt;

  modport master (
    output start, abort, cfg_bit, cfg_valid,
    input  cfg_ready, cfg_active, busy, done, hdr_err, commit_cnt
  );

  modport slave (
    input  start, abort, cfg_bit, cfg_valid,
    output cfg_ready, cfg_active, busy, done, hdr_err, commit_cnt
  );
endinterface

// File: rtl/le_config_loader_shift_reg.sv
// Shadow register for the serial genome: shifts left with the new bit
// entering at bit 0, so the first bit received ends up in the MSB.
module le_cfg_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // Clear has priority so a fresh frame never inherits stale bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= {q[WIDTH-2:0], din};
  end

endmodule

// File: rtl/le_config_loader.sv
// Configuration loader: receives sync header + payload serially, assembles
// the genome in a shadow register and commits it to cfg_active in one cycle,
// so the LE array never sees a partially loaded configuration.
module le_config_loader
  import le_cfg_pkg::*;
#(
  parameter int NUM_LE = 4
) (
  input logic     clk,
  input logic     rst,
  le_cfg_if.slave bus
);

  localparam int PAY_W = NUM_LE * CFG_W;
  localparam int CNT_W = $clog2(PAY_W + 1);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_HEADER  = HEADER;
  localparam logic [1:0] ST_PAYLOAD = PAYLOAD;
  localparam logic [1:0] ST_COMMIT  = COMMIT;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [HDR_W-1:0] hdr_q;
  logic [HDR_W-1:0] hdr_next;
  logic [PAY_W-1:0] shadow;
  logic [PAY_W-1:0] active_q;
  logic             done_q;
  logic             hdr_err_q;
  logic [7:0]       commit_q;
  logic             ready;
  logic             xfer;
  logic             hdr_last;
  logic             hdr_ok;
  logic             pay_last;
  logic             start_frame;
  logic             shadow_clr;
  logic             shadow_en;

  assign ready       = (state == ST_HEADER) || (state == ST_PAYLOAD);
  assign xfer        = bus.cfg_valid & ready;
  assign hdr_next    = {hdr_q[HDR_W-2:0], bus.cfg_bit};
  assign hdr_last    = (state == ST_HEADER) && xfer && (cnt == CNT_W'(HDR_W - 1));
  assign hdr_ok      = (hdr_next == SYNC_HDR);
  assign pay_last    = (state == ST_PAYLOAD) && xfer && (cnt == CNT_W'(PAY_W - 1));
  assign start_frame = (state == ST_IDLE) && bus.start && !bus.abort;
  assign shadow_clr  = start_frame || (bus.abort && (state != ST_IDLE));
  assign shadow_en   = (state == ST_PAYLOAD) && xfer && !bus.abort;

  assign bus.cfg_ready  = ready;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.cfg_active = active_q;
  assign bus.done       = done_q;
  assign bus.hdr_err    = hdr_err_q;
  assign bus.commit_cnt = commit_q;

  le_cfg_shift_reg #(.WIDTH(PAY_W)) u_shadow (
    .clk (clk),
    .rst (rst),
    .clr (shadow_clr),
    .en  (shadow_en),
    .din (bus.cfg_bit),
    .q   (shadow)
  );

  // Frame sequencing; the shared bit counter restarts on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_frame) begin
            state <= ST_HEADER;
            cnt   <= '0;
          end
        end
        ST_HEADER: begin
          if (bus.abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (hdr_last) begin
            state <= hdr_ok ? ST_PAYLOAD : ST_IDLE;
            cnt   <= '0;
          end else if (xfer) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (bus.abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (pay_last) begin
            state <= ST_COMMIT;
            cnt   <= '0;
          end else if (xfer) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Header bits are collected separately from the payload shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hdr_q <= '0;
    else if (start_frame)
      hdr_q <= '0;
    else if ((state == ST_HEADER) && xfer)
      hdr_q <= hdr_next;
  end

  // Atomic commit of the shadow; an abort during COMMIT suppresses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= '0;
      done_q   <= 1'b0;
      commit_q <= '0;
    end else begin
      done_q <= 1'b0;
      if ((state == ST_COMMIT) && !bus.abort) begin
        active_q <= shadow;
        done_q   <= 1'b1;
        commit_q <= commit_q + 8'd1;
      end
    end
  end

  // One-cycle header error pulse when the 8th header bit completes a bad sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hdr_err_q <= 1'b0;
    else
      hdr_err_q <= hdr_last && !hdr_ok && !bus.abort;
  end

endmodule

// File: tb/tb_le_config_loader.sv
// Self-checking bench for le_config_loader with two logic elements.
// A frame-level model predicts the committed genome and commit count.
module tb_le_config_loader;

  localparam int         NUM_LE = 2;
  localparam logic [7:0] SYNC   = 8'hA5;

  logic clk;
  logic rst;

  le_cfg_if #(.NUM_LE(NUM_LE)) bus ();

  le_config_loader #(.NUM_LE(NUM_LE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          doneCount  = 0;
  int          readyViol  = 0;
  int          expDones   = 0;
  logic [63:0] expActive  = '0;
  logic [7:0]  expCnt     = '0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index used to measure start-to-done latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Count done pulses and any cycle where ready is offered outside a frame.
  always @(negedge clk) begin
    if (bus.done) doneCount <= doneCount + 1;
    if (!rst && bus.cfg_ready && !bus.busy) readyViol <= readyViol + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    expActive = '0;
    expCnt    = '0;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_active"}, bus.cfg_active, expActive);
    checkOutput({tag, "_cnt"}, 64'(bus.commit_cnt), 64'(expCnt));
    checkOutput({tag, "_dones"}, 64'(doneCount), 64'(expDones));
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  // Send one frame. abortAt: -1 none, 0..63 abort with that payload bit,
  // 64 abort during the commit cycle.
  task automatic applyStimulus(input logic [7:0] hdr, input logic [63:0] pay,
                               input bit randValid, input int abortAt, input bit randStart);
    logic [71:0] frame;
    int          total;
    int          i;
    int          budget;
    int          startCyc;
    bit          aborted;
    bit          rdy;
    frame    = {hdr, pay};
    total    = (hdr == SYNC) ? 72 : 8;
    i        = 0;
    budget   = 0;
    aborted  = 1'b0;
    bus.start = 1'b1;
    tick();
    startCyc  = cyc;
    bus.start = 1'b0;
    checkOutput("busy_after_start", 64'(bus.busy), 64'd1);
    while (i < total && !aborted && budget < 2000) begin
      bus.cfg_valid = randValid ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.cfg_bit   = frame[71-i];
      bus.abort     = 1'b0;
      if (abortAt >= 0 && abortAt < 64 && i == 8 + abortAt) begin
        bus.abort     = 1'b1;
        bus.cfg_valid = 1'b1;
      end
      bus.start = randStart && ($urandom_range(0, 3) == 0);
      rdy = bus.cfg_ready;
      tick();
      if (rdy && bus.cfg_valid) begin
        if (bus.abort) aborted = 1'b1;
        i++;
      end
      budget++;
    end
    bus.cfg_valid = 1'b0;
    bus.abort     = 1'b0;
    bus.start     = 1'b0;
    if (!aborted) checkOutput("bits_accepted", 64'(i), 64'(total));
    if (aborted) begin
      checkOutput("abort_idle", 64'(bus.busy), 64'd0);
      checkOutput("abort_no_done", 64'(bus.done), 64'd0);
    end else if (hdr != SYNC) begin
      checkOutput("hdr_err_pulse", 64'(bus.hdr_err), 64'd1);
      checkOutput("hdr_busy", 64'(bus.busy), 64'd0);
      tick();
      checkOutput("hdr_err_clear", 64'(bus.hdr_err), 64'd0);
    end else begin
      checkOutput("commit_ready", 64'(bus.cfg_ready), 64'd0);
      checkOutput("commit_busy", 64'(bus.busy), 64'd1);
      if (abortAt == 64) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checkOutput("abort_commit_done", 64'(bus.done), 64'd0);
      end else begin
        tick();
        checkOutput("done_pulse", 64'(bus.done), 64'd1);
        if (!randValid) checkOutput("latency", 64'(cyc - startCyc), 64'd73);
        tick();
        checkOutput("done_clear", 64'(bus.done), 64'd0);
      end
    end
    if (hdr == SYNC && !aborted && abortAt != 64) begin
      expActive = pay;
      expCnt    = expCnt + 8'd1;
      expDones++;
    end
    tick();
  endtask

  initial begin
    logic [63:0] p;
    logic [7:0]  h;
    int          ab;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.cfg_bit   = 1'b0;
    bus.cfg_valid = 1'b0;
    tick();
    doReset();
    checkOutput("rst_active", bus.cfg_active, 64'd0);
    checkOutput("rst_cnt", 64'(bus.commit_cnt), 64'd0);
    checkOutput("rst_ready", 64'(bus.cfg_ready), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_hdr_err", 64'(bus.hdr_err), 64'd0);

    applyStimulus(8'hA5, 64'h0123_4567_89AB_CDEF, 1'b0, -1, 1'b0);
    checkModel("s1");
    checkOutput("s1_le0_lut", 64'(bus.cfg_active[15:0]), 64'h0000_0000_0000_CDEF);
    checkOutput("s1_le1_south", 64'(bus.cfg_active[63:62]), 64'd0);

    applyStimulus(8'hA4, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, -1, 1'b0);
    checkModel("s2");

    applyStimulus(8'hA5, 64'h0123_4567_89AB_CDEF, 1'b1, -1, 1'b0);
    checkModel("s3");

    applyStimulus(8'hA5, {$urandom, $urandom}, 1'b0, 40, 1'b0);
    checkModel("s4a");
    applyStimulus(8'hA5, 64'hFFFF_0000_FFFF_0000, 1'b0, -1, 1'b0);
    checkModel("s4b");

    applyStimulus(8'hA5, {$urandom, $urandom}, 1'b1, 63, 1'b1);
    checkModel("s5a");
    applyStimulus(8'hA5, {$urandom, $urandom}, 1'b0, 64, 1'b1);
    checkModel("s5b");

    for (int k = 0; k < 20; k++) begin
      p  = {$urandom, $urandom};
      h  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : SYNC;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 64)) : -1;
      applyStimulus(h, p, 1'b1, ab, 1'b1);
      checkModel("rand");
    end

    doReset();
    for (int k = 0; k < 256; k++) begin
      applyStimulus(SYNC, {$urandom, $urandom}, 1'b0, -1, 1'b0);
      checkModel("b2b");
    end
    checkOutput("wrap_cnt", 64'(bus.commit_cnt), 64'd0);

    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.cfg_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      bus.cfg_bit = 1'($urandom);
      tick();
    end
    bus.cfg_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_active", bus.cfg_active, 64'd0);
    checkOutput("async_cnt", 64'(bus.commit_cnt), 64'd0);
    checkOutput("async_busy", 64'(bus.busy), 64'd0);
    checkOutput("async_ready", 64'(bus.cfg_ready), 64'd0);
    expActive = '0;
    expCnt    = '0;
    tick();
    rst = 1'b0;
    tick();
    checkModel("post_rst");

    applyStimulus(SYNC, 64'h5A5A_1234_C3C3_8765, 1'b1, -1, 1'b0);
    checkModel("final");
    checkOutput("ready_outside_frame", 64'(readyViol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
